// File: rtl/div8_seq_pkg.sv
// Shared types and limits for the sequential divider.
package div_pkg;

  // Controller states: IDLE waits for start, RUN iterates, DONE publishes the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Widest operand the divider is built for.
  localparam int unsigned DIV_WMAX = 16;

endpackage : div_pkg

// File: rtl/div8_seq_if.sv
// Start/done handshake and operand/result bus of the sequential divider.
//   start, a, b                  : requester -> divider
//   busy, done, q, r, div_by_zero: divider -> requester
interface div8_seq_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             div_by_zero;

  modport master (
    output start, a, b,
    input  busy, done, q, r, div_by_zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, q, r, div_by_zero
  );

endinterface : div8_seq_if

// File: rtl/div8_seq_shsub.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, then subtract the divisor if it fits and set the quotient bit.
//   rem_i/rem_o : partial remainder before/after the step (always < b_i)
//   quo_i/quo_o : dividend/quotient shift register before/after the step
//   b_i         : divisor
module shsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  // One extra bit so the shifted remainder never overflows the compare.
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] b_ext;
  logic [WIDTH:0] rem_sub;

  always_comb begin
    rem_sh  = {rem_i, quo_i[WIDTH-1]};
    b_ext   = {1'b0, b_i};
    rem_sub = rem_sh - b_ext;
    rem_o   = rem_sh[WIDTH-1:0];
    quo_o   = {quo_i[WIDTH-2:0], 1'b0};
    if (rem_sh >= b_ext) begin
      // Result is < b_i, so it fits back in WIDTH bits.
      rem_o = rem_sub[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule : shsub

// File: rtl/div8_seq.sv
// Sequential unsigned divider: q = a / b, r = a % b, one restoring step per
// clock behind a start/done handshake.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of div8_seq_if (start/a/b in; busy/done/q/r/div_by_zero out)
// Timing: accepted start with b != 0 -> done WIDTH+1 clocks later;
// b == 0 -> done one clock later with q = all ones, r = a.
module div8_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  div8_seq_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  if (WIDTH < 2 || WIDTH > DIV_WMAX) begin : g_bad_width
    $error("div8_seq: WIDTH out of range");
  end

  div_state_t       state;
  div_state_t       state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] bq;
  logic             dz;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] rem_step;

  // Single step cell shared by every RUN cycle.
  shsub #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem),
    .quo_i (quo),
    .b_i   (bq),
    .rem_o (rem_step),
    .quo_o (quo_step)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a zero divisor skips RUN entirely.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = (bus.b == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt == '0) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs. busy tracks the state one edge ahead so
  // it is high exactly while the FSM is out of IDLE; done/q/r load as DONE
  // retires, so the result cycle already has busy low and accepts a new start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt             <= '0;
      quo             <= '0;
      rem             <= '0;
      bq              <= '0;
      dz              <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.q           <= '0;
      bus.r           <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.busy <= (state_next != IDLE);
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            quo <= bus.a;
            rem <= '0;
            bq  <= bus.b;
            dz  <= (bus.b == '0);
            cnt <= CW'(WIDTH - 1);
          end
        end
        RUN: begin
          quo <= quo_step;
          rem <= rem_step;
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          // On divide-by-zero quo still holds the untouched dividend.
          bus.done        <= 1'b1;
          bus.q           <= dz ? '1 : quo;
          bus.r           <= dz ? quo : rem;
          bus.div_by_zero <= dz;
        end
        default: ;
      endcase
    end
  end

endmodule : div8_seq

// File: tb/tb_div8_seq.sv
// Directed and randomized checks of div8_seq: results, latency, busy window,
// divide-by-zero, ignored start while busy, back-to-back start, mid-op reset.
module tb_div8_seq;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  div8_seq_if #(.WIDTH(8)) bus ();

  div8_seq #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Called on the negedge of the first cycle after acceptance; returns the
  // cycle index where done is seen and the number of busy cycles before it.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = bus.busy ? 1 : 0;
    while (!bus.done && lat < 30) begin
      @(negedge clk);
      lat++;
      if (bus.busy) bcnt++;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input logic edz,
                        input int elat);
    int lat;
    int bcnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = ~b;
    wait_done(lat, bcnt);
    check({tag, ".done_seen"}, 32'(bus.done), 32'd1);
    check({tag, ".latency"}, 32'(lat), 32'(elat));
    check({tag, ".busy_cycles"}, 32'(bcnt), 32'(elat));
    check({tag, ".q"}, 32'(bus.q), 32'(eq));
    check({tag, ".r"}, 32'(bus.r), 32'(er));
    check({tag, ".dz"}, 32'(bus.div_by_zero), 32'(edz));
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, ".q_held"}, 32'(bus.q), 32'(eq));
  endtask

  initial begin
    int lat;
    int bcnt;
    int seen;
    logic [7:0] ra;
    logic [7:0] rb;
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    check("rst.q", 32'(bus.q), 32'd0);
    check("rst.r", 32'(bus.r), 32'd0);
    check("rst.dz", 32'(bus.div_by_zero), 32'd0);
    rst_n = 1'b1;

    // Directed vectors.
    run_op("d200_7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 9);
    run_op("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9);
    run_op("d5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 9);
    run_op("d0_3", 8'd0, 8'd3, 8'd0, 8'd0, 1'b0, 9);
    run_op("d77_0", 8'd77, 8'd0, 8'hFF, 8'd77, 1'b1, 1);
    run_op("d10_3", 8'd10, 8'd3, 8'd3, 8'd1, 1'b0, 9);
    run_op("d255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 9);
    run_op("d254_255", 8'd254, 8'd255, 8'd0, 8'd254, 1'b0, 9);

    // Start while busy is ignored; start held into the result cycle is accepted.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd100;
    bus.b     = 8'd10;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd9;
    bus.b     = 8'd9;
    lat  = 0;
    bcnt = 0;
    while (!bus.done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("b2b.first_latency", 32'(lat + 4), 32'd9);
    check("b2b.first_q", 32'(bus.q), 32'd10);
    check("b2b.first_r", 32'(bus.r), 32'd0);
    check("b2b.first_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b.second_busy", 32'(bus.busy), 32'd1);
    wait_done(lat, bcnt);
    check("b2b.second_latency", 32'(lat), 32'd9);
    check("b2b.second_q", 32'(bus.q), 32'd1);
    check("b2b.second_r", 32'(bus.r), 32'd0);
    @(negedge clk);

    // Reset mid-operation clears everything and suppresses done.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd200;
    bus.b     = 8'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst.busy", 32'(bus.busy), 32'd0);
    check("mid_rst.q", 32'(bus.q), 32'd0);
    check("mid_rst.r", 32'(bus.r), 32'd0);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check("mid_rst.no_done", 32'(seen), 32'd0);
    run_op("restart", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 9);

    // Random sweep against the arithmetic reference.
    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(1, 255));
      run_op("rand", ra, rb, ra / rb, ra % rb, 1'b0, 9);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_div8_seq
